// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: predictor-update record and branch funct3 codes.
// Update records are sized for the widest supported datapath; the top zero-extends into them.
package branch_resolve_unit_pkg;

  localparam int UPD_XLEN = 64;
  localparam int UPD_ID_W = 8;

  localparam logic [2:0] FN3_BEQ  = 3'b000;
  localparam logic [2:0] FN3_BNE  = 3'b001;
  localparam logic [2:0] FN3_BLT  = 3'b100;
  localparam logic [2:0] FN3_BGE  = 3'b101;
  localparam logic [2:0] FN3_BLTU = 3'b110;
  localparam logic [2:0] FN3_BGEU = 3'b111;

  typedef struct packed {
    logic [UPD_XLEN-1:0] pc;
    logic [UPD_XLEN-1:0] target;
    logic                taken;
    logic                is_branch;
    logic                is_call;
    logic                is_return;
    logic [UPD_ID_W-1:0] id;
  } branch_update_t;

endpackage

// File: rtl/branch_comparator.sv
// Branch condition evaluator: signed compare except for BLTU/BGEU.
module branch_comparator
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      fn3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            result
);

  logic is_unsigned;
  logic eq;
  logic lt;

  always_comb begin
    is_unsigned = (fn3 == FN3_BLTU) || (fn3 == FN3_BGEU);
    eq          = (a == b);
    lt          = is_unsigned ? (a < b) : ($signed(a) < $signed(b));
    result      = 1'b0;
    case (fn3)
      FN3_BEQ:            result = eq;
      FN3_BNE:            result = !eq;
      FN3_BLT, FN3_BLTU:  result = lt;
      FN3_BGE, FN3_BGEU:  result = !lt;
      default:            result = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_update_fifo.sv
// First-word-fall-through FIFO of predictor update records with an occupancy count.
module branch_update_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  branch_update_t push_data,
  input  logic           pop,
  output branch_update_t head,
  output logic           empty,
  output logic [CNT_W-1:0] count
);

  branch_update_t   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign do_push = push && (count_reg != CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage is left unreset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Issue-stage branch/jump resolver: holds the resolved PC until the successor issues,
// flushes on a mismatch and queues predictor updates with backpressure.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int C_EXT     = 0,
  parameter int UPD_DEPTH = 4,
  parameter int ID_W      = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [ID_W-1:0] issue_id,
  input  logic [2:0]      issue_fn3,
  input  logic            issue_jal,
  input  logic            issue_jalr,
  input  logic            issue_call,
  input  logic            issue_return,
  input  logic [XLEN-1:0] issue_pc,
  input  logic [20:0]     issue_offset,
  input  logic [XLEN-1:0] fallthrough_pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            next_valid,
  input  logic [XLEN-1:0] next_pc,
  input  logic            squash,
  output logic            branch_flush,
  output logic [XLEN-1:0] flush_pc,
  output logic            exc_valid,
  output logic [XLEN-1:0] exc_tval,
  output logic [XLEN-1:0] exc_pc,
  output logic            upd_valid,
  input  logic            upd_ready,
  output logic [XLEN-1:0] upd_pc,
  output logic [XLEN-1:0] upd_target,
  output logic            upd_taken,
  output logic            upd_is_branch,
  output logic            upd_is_call,
  output logic            upd_is_return,
  output logic [ID_W-1:0] upd_id,
  output logic [31:0]     mispredict_cnt
);

  localparam int  CNT_W       = $clog2(UPD_DEPTH) + 1;
  localparam bit  CHECK_ALIGN = (C_EXT == 0);

  logic            accept, cmp_taken, taken, misaligned, resolve;
  logic [XLEN-1:0] target_sum, target, new_pc;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]  occupancy;
  logic            fifo_empty, fifo_unused;
  branch_update_t  push_rec, head_rec;

  logic            pend_reg, pend_taken_reg, pend_branch_reg, pend_call_reg, pend_return_reg;
  logic [XLEN-1:0] pend_new_pc_reg, pend_pc_reg;
  logic [ID_W-1:0] pend_id_reg;
  logic            exc_valid_reg;
  logic [XLEN-1:0] exc_tval_reg, exc_pc_reg;
  logic [31:0]     cnt_reg;

  branch_comparator #(.XLEN(XLEN)) u_cmp (
    .fn3    (issue_fn3),
    .a      (rs1),
    .b      (rs2),
    .result (cmp_taken)
  );

  assign occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pend_reg};
  assign issue_ready = occupancy < (CNT_W+1)'(UPD_DEPTH);
  assign accept      = issue_valid && issue_ready;

  assign taken      = issue_jal || issue_jalr || cmp_taken;
  assign target_sum = (issue_jalr ? rs1 : issue_pc) + {{(XLEN-21){issue_offset[20]}}, issue_offset};
  assign target     = {target_sum[XLEN-1:1], target_sum[0] & ~issue_jalr};
  assign new_pc     = taken ? target : fallthrough_pc;
  assign misaligned = CHECK_ALIGN && taken && new_pc[1];

  // Squash wins over resolve: the held result belongs to a discarded path.
  assign resolve      = pend_reg && next_valid && !squash;
  assign branch_flush = resolve && (next_pc[XLEN-1:1] != pend_new_pc_reg[XLEN-1:1]);
  assign flush_pc     = pend_new_pc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_reg        <= 1'b0;
      pend_new_pc_reg <= '0;
      pend_pc_reg     <= '0;
      pend_taken_reg  <= 1'b0;
      pend_branch_reg <= 1'b0;
      pend_call_reg   <= 1'b0;
      pend_return_reg <= 1'b0;
      pend_id_reg     <= '0;
      exc_valid_reg   <= 1'b0;
      exc_tval_reg    <= '0;
      exc_pc_reg      <= '0;
      cnt_reg         <= '0;
    end else begin
      if (accept && !misaligned) begin
        pend_reg        <= 1'b1;
        pend_new_pc_reg <= new_pc;
        pend_pc_reg     <= issue_pc;
        pend_taken_reg  <= taken;
        pend_branch_reg <= !issue_jal && !issue_jalr;
        pend_call_reg   <= issue_call;
        pend_return_reg <= issue_return;
        pend_id_reg     <= issue_id;
      end else if (squash || (pend_reg && next_valid)) begin
        pend_reg <= 1'b0;
      end
      exc_valid_reg <= accept && misaligned;
      if (accept && misaligned) begin
        exc_tval_reg <= new_pc;
        exc_pc_reg   <= issue_pc;
      end
      if (branch_flush) cnt_reg <= cnt_reg + 32'd1;
    end
  end

  always_comb begin
    push_rec           = '0;
    push_rec.pc        = UPD_XLEN'(pend_pc_reg);
    push_rec.target    = UPD_XLEN'(pend_new_pc_reg);
    push_rec.taken     = pend_taken_reg;
    push_rec.is_branch = pend_branch_reg;
    push_rec.is_call   = pend_call_reg;
    push_rec.is_return = pend_return_reg;
    push_rec.id        = UPD_ID_W'(pend_id_reg);
  end

  branch_update_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (resolve),
    .push_data (push_rec),
    .pop       (upd_valid && upd_ready),
    .head      (head_rec),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Upper record bits beyond XLEN/ID_W are always zero.
  assign fifo_unused = ^head_rec;

  assign upd_valid      = !fifo_empty;
  assign upd_pc         = upd_valid ? head_rec.pc[XLEN-1:0] : '0;
  assign upd_target     = upd_valid ? head_rec.target[XLEN-1:0] : '0;
  assign upd_taken      = upd_valid && head_rec.taken;
  assign upd_is_branch  = upd_valid && head_rec.is_branch;
  assign upd_is_call    = upd_valid && head_rec.is_call;
  assign upd_is_return  = upd_valid && head_rec.is_return;
  assign upd_id         = upd_valid ? head_rec.id[ID_W-1:0] : '0;

  assign exc_valid      = exc_valid_reg;
  assign exc_tval       = exc_tval_reg;
  assign exc_pc         = exc_pc_reg;
  assign mispredict_cnt = cnt_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: stimulus runs a transaction-level model and queues expectations,
// a negedge monitor compares them against the DUT.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        issue_valid, issue_ready, issue_jal, issue_jalr, issue_call, issue_return;
  logic [2:0]  issue_id, issue_fn3;
  logic [31:0] issue_pc, fallthrough_pc, rs1, rs2, next_pc;
  logic [20:0] issue_offset;
  logic        next_valid, squash, upd_ready;
  logic        branch_flush, exc_valid, upd_valid, upd_taken, upd_is_branch, upd_is_call, upd_is_return;
  logic [31:0] flush_pc, exc_tval, exc_pc, upd_pc, upd_target, mispredict_cnt;
  logic [2:0]  upd_id;
  logic        issue_ready_c, branch_flush_c, exc_valid_c, upd_valid_c, upd_taken_c;
  logic        upd_is_branch_c, upd_is_call_c, upd_is_return_c;
  logic [31:0] flush_pc_c, exc_tval_c, exc_pc_c, upd_pc_c, upd_target_c, mispredict_cnt_c;
  logic [2:0]  upd_id_c;

  branch_resolve_unit #(.XLEN(32), .C_EXT(0), .UPD_DEPTH(DEPTH), .ID_W(3)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_id(issue_id),
    .issue_fn3(issue_fn3), .issue_jal(issue_jal), .issue_jalr(issue_jalr), .issue_call(issue_call),
    .issue_return(issue_return), .issue_pc(issue_pc), .issue_offset(issue_offset),
    .fallthrough_pc(fallthrough_pc), .rs1(rs1), .rs2(rs2), .next_valid(next_valid), .next_pc(next_pc),
    .squash(squash), .branch_flush(branch_flush), .flush_pc(flush_pc), .exc_valid(exc_valid),
    .exc_tval(exc_tval), .exc_pc(exc_pc), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken), .upd_is_branch(upd_is_branch),
    .upd_is_call(upd_is_call), .upd_is_return(upd_is_return), .upd_id(upd_id),
    .mispredict_cnt(mispredict_cnt));

  // Compressed-mode instance, only observed in the first directed case.
  branch_resolve_unit #(.XLEN(32), .C_EXT(1), .UPD_DEPTH(DEPTH), .ID_W(3)) dut_c (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready_c), .issue_id(issue_id),
    .issue_fn3(issue_fn3), .issue_jal(issue_jal), .issue_jalr(issue_jalr), .issue_call(issue_call),
    .issue_return(issue_return), .issue_pc(issue_pc), .issue_offset(issue_offset),
    .fallthrough_pc(fallthrough_pc), .rs1(rs1), .rs2(rs2), .next_valid(next_valid), .next_pc(next_pc),
    .squash(squash), .branch_flush(branch_flush_c), .flush_pc(flush_pc_c), .exc_valid(exc_valid_c),
    .exc_tval(exc_tval_c), .exc_pc(exc_pc_c), .upd_valid(upd_valid_c), .upd_ready(upd_ready),
    .upd_pc(upd_pc_c), .upd_target(upd_target_c), .upd_taken(upd_taken_c),
    .upd_is_branch(upd_is_branch_c), .upd_is_call(upd_is_call_c), .upd_is_return(upd_is_return_c),
    .upd_id(upd_id_c), .mispredict_cnt(mispredict_cnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rdy, uv, flush, exc;
    logic [31:0] fpc, cnt, tval, epc;
  } cyc_t;
  typedef struct {
    logic [31:0] pc, target;
    logic taken, br, call, ret;
    logic [2:0] id;
  } upd_t;

  cyc_t cyc_q[$];
  upd_t upd_q[$];
  int   tests = 0, fails = 0;
  bit   mon_en = 0;

  // Reference model state: held resolution, FIFO occupancy, counter, pending exception.
  int          m_cnt = 0;
  bit          m_pend = 0, m_exc = 0;
  upd_t        m_rec;
  logic [31:0] m_mis = 0, m_tval = 0, m_epc = 0;
  logic [2:0]  next_id = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit cond_true(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Applies the resolution rules to the inputs currently driven and queues what the DUT must show.
  task automatic step();
    cyc_t e;
    bit resolve, pop, accept, taken, mis;
    logic [31:0] tgt, np;
    e.rdy = (m_cnt + int'(m_pend)) < DEPTH;
    e.uv  = m_cnt > 0;
    e.exc = m_exc; e.tval = m_tval; e.epc = m_epc;
    e.cnt = m_mis;
    resolve = m_pend && next_valid && !squash;
    e.flush = resolve && (next_pc[31:1] != m_rec.target[31:1]);
    e.fpc   = m_rec.target;
    if (e.flush) m_mis = m_mis + 1;
    pop    = (m_cnt > 0) && upd_ready;
    accept = issue_valid && e.rdy;
    tgt = (issue_jalr ? rs1 : issue_pc) + 32'($signed(issue_offset));
    if (issue_jalr) tgt[0] = 1'b0;
    taken = issue_jal || issue_jalr || cond_true(issue_fn3, rs1, rs2);
    np  = taken ? tgt : fallthrough_pc;
    mis = taken && np[1];
    m_exc = accept && mis; m_tval = np; m_epc = issue_pc;
    if (resolve) begin upd_q.push_back(m_rec); m_cnt++; end
    if (pop) m_cnt--;
    if (accept && !mis) begin
      m_pend = 1;
      m_rec = '{pc: issue_pc, target: np, taken: taken, br: !(issue_jal || issue_jalr),
                call: issue_call, ret: issue_return, id: issue_id};
    end else if (squash || (m_pend && next_valid)) begin
      m_pend = 0;
    end
    cyc_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    issue_valid = 0; issue_jal = 0; issue_jalr = 0; issue_call = 0; issue_return = 0;
    next_valid = 0; squash = 0;
  endtask

  task automatic set_br(logic [2:0] f, logic jal, logic jalr, logic [31:0] pc, logic [20:0] off,
                        logic [31:0] a, logic [31:0] b);
    issue_valid = 1; issue_fn3 = f; issue_jal = jal; issue_jalr = jalr;
    issue_call = 0; issue_return = 0; issue_pc = pc; issue_offset = off;
    fallthrough_pc = pc + 32'd4; rs1 = a; rs2 = b;
    issue_id = next_id; next_id = next_id + 3'd1;
  endtask

  always @(negedge clk) begin
    if (mon_en && cyc_q.size() > 0) begin
      cyc_t e;
      upd_t g;
      e = cyc_q.pop_front();
      chk("issue_ready", 32'(issue_ready), 32'(e.rdy));
      chk("upd_valid", 32'(upd_valid), 32'(e.uv));
      chk("branch_flush", 32'(branch_flush), 32'(e.flush));
      chk("mispredict_cnt", mispredict_cnt, e.cnt);
      chk("exc_valid", 32'(exc_valid), 32'(e.exc));
      if (e.flush) chk("flush_pc", flush_pc, e.fpc);
      if (e.exc) begin
        chk("exc_tval", exc_tval, e.tval);
        chk("exc_pc", exc_pc, e.epc);
      end
      if (upd_valid && upd_ready && upd_q.size() > 0) begin
        g = upd_q.pop_front();
        $display("[TB] update id=%0d pc=0x%0h target=0x%0h taken=%0b", upd_id, upd_pc, upd_target, upd_taken);
        chk("upd_pc", upd_pc, g.pc);
        chk("upd_target", upd_target, g.target);
        chk("upd_flags", {28'd0, upd_taken, upd_is_branch, upd_is_call, upd_is_return},
            {28'd0, g.taken, g.br, g.call, g.ret});
        chk("upd_id", 32'(upd_id), 32'(g.id));
      end
    end
  end

  logic [2:0] fn3_tab [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  task automatic rand_cycle(int cyc);
    int kind, off;
    kind = int'($urandom_range(0, 7));
    set_br(fn3_tab[$urandom_range(0, 5)], kind == 0, kind == 1,
           $urandom_range(0, 'hFFFF) & 32'hFFFF_FFFC, 21'd0,
           ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 3)));
    off = int'($urandom_range(0, 255)) * 4 + (($urandom_range(0, 7) == 0) ? 2 : 0);
    if ($urandom_range(0, 1) == 1) off = -off;
    issue_offset = 21'(off);
    if (issue_jalr) rs1 = 32'($urandom_range(0, 'hFFFF));
    issue_call   = issue_jal && ($urandom_range(0, 1) == 1);
    issue_return = issue_jalr && ($urandom_range(0, 1) == 1);
    issue_valid  = ($urandom_range(0, 1) == 1);
    next_valid   = (m_pend && issue_valid) ? 1'b1 : ($urandom_range(0, 9) < 6);
    next_pc      = (m_pend && $urandom_range(0, 1) == 1) ? m_rec.target
                                                          : ($urandom_range(0, 'hFFFF) & 32'hFFFF_FFFC);
    squash       = ($urandom_range(0, 15) == 0);
    upd_ready    = (cyc >= 100 && cyc < 160) ? 1'b0 : ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    rst = 0; upd_ready = 1; issue_id = 0; issue_fn3 = 0; issue_pc = 0; issue_offset = 0;
    fallthrough_pc = 0; rs1 = 0; rs2 = 0; next_pc = 0;
    idle_in();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset issue_ready", 32'(issue_ready), 32'd1);
    chk("reset upd_valid", 32'(upd_valid), 32'd0);
    chk("reset exc_valid", 32'(exc_valid), 32'd0);
    chk("reset branch_flush", 32'(branch_flush), 32'd0);
    chk("reset mispredict_cnt", mispredict_cnt, 32'd0);
    rst = 1;
    tick();
    mon_en = 1;

    // JALR to a 2-byte-aligned target: exception without C, redirect with C.
    set_br(3'd0, 0, 1, 32'h80, 21'd0, 32'h1003, 32'd0); step(); tick();
    idle_in(); next_valid = 1; next_pc = 32'h84; step(); #3;
    chk("jalr exc_valid", 32'(exc_valid), 32'd1);
    chk("jalr exc_tval", exc_tval, 32'h1002);
    chk("jalr C exc_valid", 32'(exc_valid_c), 32'd0);
    chk("jalr C branch_flush", 32'(branch_flush_c), 32'd1);
    chk("jalr C flush_pc", flush_pc_c, 32'h1002);
    tick();

    // BEQ taken and correctly followed.
    set_br(3'd0, 0, 0, 32'h100, 21'h20, 32'd5, 32'd5); step(); tick();
    idle_in(); next_valid = 1; next_pc = 32'h120; step(); #3;
    chk("beq branch_flush", 32'(branch_flush), 32'd0); tick();

    // BLT signed-taken mispredicted, then BLTU with the same operands not taken.
    set_br(3'd4, 0, 0, 32'h200, 21'h10, 32'hFFFF_FFFF, 32'd1); step(); tick();
    idle_in(); next_valid = 1; next_pc = 32'h204; step(); #3;
    chk("blt branch_flush", 32'(branch_flush), 32'd1);
    chk("blt flush_pc", flush_pc, 32'h210); tick();
    idle_in(); step(); #3;
    chk("blt mispredict_cnt", mispredict_cnt, 32'd1); tick();
    set_br(3'd6, 0, 0, 32'h200, 21'h10, 32'hFFFF_FFFF, 32'd1); step(); tick();
    idle_in(); next_valid = 1; next_pc = 32'h204; step(); #3;
    chk("bltu branch_flush", 32'(branch_flush), 32'd0); tick();

    // Back-to-back branches with the predictor stalled, then drain.
    idle_in(); upd_ready = 0; step(); tick();
    set_br(3'd0, 0, 0, 32'h300, 21'h8, 32'd1, 32'd1); step(); tick();
    for (int k = 1; k <= 5; k++) begin
      set_br(3'd1, 0, 0, 32'h300 + 32'(4 * k), 21'h8, 32'd1, 32'd2);
      next_valid = 1; next_pc = 32'h300 + 32'(4 * k);
      step(); #3;
      if (k == 4) chk("stall issue_ready", 32'(issue_ready), 32'd0);
      tick();
    end
    idle_in(); upd_ready = 1;
    repeat (6) begin step(); tick(); end
    chk("drained ready", 32'(issue_ready), 32'd1);

    // Squash in the resolve cycle, with a new branch accepted alongside.
    set_br(3'd1, 0, 0, 32'h400, 21'h40, 32'd1, 32'd2); step(); tick();
    set_br(3'd0, 0, 0, 32'h404, 21'h80, 32'd3, 32'd3);
    next_valid = 1; next_pc = 32'h404; squash = 1; step(); #3;
    chk("squash branch_flush", 32'(branch_flush), 32'd0); tick();
    idle_in(); next_valid = 1; next_pc = 32'h408; step(); #3;
    chk("post-squash flush_pc", flush_pc, 32'h484); tick();
    idle_in(); step(); tick();

    for (int c = 0; c < 400; c++) begin
      rand_cycle(c); step(); tick();
    end
    idle_in(); upd_ready = 1; next_valid = 1; next_pc = 32'hFFFF_0000; step(); tick();
    idle_in();
    repeat (8) begin step(); tick(); end
    chk("updates outstanding", 32'(upd_q.size()), 32'd0);

    // Reset while pending with two entries waiting in the update FIFO.
    upd_ready = 0;
    set_br(3'd0, 0, 0, 32'h500, 21'h8, 32'd1, 32'd1); step(); tick();
    set_br(3'd0, 0, 0, 32'h504, 21'h8, 32'd1, 32'd1); next_valid = 1; next_pc = 32'h504; step(); tick();
    set_br(3'd0, 0, 0, 32'h508, 21'h8, 32'd1, 32'd1); next_valid = 1; next_pc = 32'h508; step(); tick();
    mon_en = 0;
    idle_in(); next_valid = 1; next_pc = 32'hDEAD_0000; #1;
    chk("pre-reset branch_flush", 32'(branch_flush), 32'd1);
    rst = 0; #1;
    chk("async reset issue_ready", 32'(issue_ready), 32'd1);
    chk("async reset upd_valid", 32'(upd_valid), 32'd0);
    chk("async reset exc_valid", 32'(exc_valid), 32'd0);
    chk("async reset branch_flush", 32'(branch_flush), 32'd0);
    chk("async reset mispredict_cnt", mispredict_cnt, 32'd0);
    cyc_q.delete(); upd_q.delete();
    #10 rst = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised successor branch/jump resolution unit for the issue stage.
- Evaluates conditional branches, JAL and JALR at issue and holds the result until the next instruction reaches issue.
- Raises a flush with a corrected PC when the successor's PC differs from the resolved PC.
- Adds, over the previous generation: XLEN/compressed-mode generalisation, a backpressured predictor-update FIFO, issue stall on FIFO pressure, squash handling and a mispredict counter.

Parameters:
XLEN, 32, datapath/PC width.
C_EXT, 0, 1 = 2-byte instruction alignment; misaligned-target exception disabled.
UPD_DEPTH, 4, predictor-update FIFO entries; power of two, at least 2.
ID_W, 3, instruction id width.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
issue_valid  in  1  branch/jump issued this cycle
issue_ready  out  1  unit can accept an issue
issue_id  in  ID_W  instruction id
issue_fn3  in  3  branch funct3
issue_jal / issue_jalr  in  1 each  jump kind
issue_call / issue_return  in  1 each  RAS hints
issue_pc  in  XLEN  branch PC
issue_offset  in  21  sign-extended immediate, byte units
fallthrough_pc  in  XLEN  PC of the next sequential instruction
rs1 / rs2  in  XLEN each  operands
next_valid  in  1  successor instruction valid at issue
next_pc  in  XLEN  successor PC
squash  in  1  external pipeline flush
branch_flush  out  1  misprediction, combinational
flush_pc  out  XLEN  corrected PC
exc_valid  out  1  misaligned-target exception
exc_tval / exc_pc  out  XLEN each  offending target / branch PC
upd_valid  out  1  predictor update available
upd_ready  in  1  predictor accepts update
upd_pc / upd_target  out  XLEN each  update payload
upd_taken / upd_is_branch / upd_is_call / upd_is_return  out  1 each  update flags
upd_id  out  ID_W  update id
mispredict_cnt  out  32  flush counter

Behaviour:
- Reset (rst=0, async): pending=0, FIFO empty, all outputs 0 except issue_ready=1. mispredict_cnt=0.
- Accept: an issue is accepted when issue_valid & issue_ready.
- Compare: signed unless fn3 is BLTU/BGEU; produced by branch_comparator (codebase's existing comparator module; same module, not a new sub-block).
- taken = jal | jalr | compare result.
- target = (jalr ? rs1 : issue_pc) + sext(issue_offset); JALR clears bit 0.
- new_pc = taken ? target : fallthrough_pc.
- Pending register: on accept, load {new_pc, taken, pc, id, flags}; pending=1.
- Misaligned target (C_EXT=0, taken, new_pc[1]=1): exc_valid=1 on the cycle after accept; exc_tval=new_pc, exc_pc=issue_pc. Pending is not set, so no flush and no update is produced. With C_EXT=1, exc_valid is tied to 0.
- Resolve: first cycle with pending & next_valid. The earliest possible is the cycle after accept.
  - branch_flush = next_pc[XLEN-1:1] != new_pc[XLEN-1:1], combinational that cycle; flush_pc = new_pc.
  - The update record is pushed into the FIFO the same cycle.
  - pending clears unless a new accept occurs in the same cycle; a back-to-back branch (the branch is itself the successor) reloads pending.
- squash: clears pending with no flush and no update push. FIFO contents are retained because those branches are already resolved. Squash has priority over resolve in the same cycle; an accept in the same cycle is still loaded.
- Stall: issue_ready = (fifo_count + pending) < UPD_DEPTH. The FIFO therefore can never overflow.
- FIFO: pop on upd_valid & upd_ready; upd_valid = !empty. Simultaneous push and pop keeps count. Pointers wrap modulo UPD_DEPTH; count width is log2(UPD_DEPTH)+1.
- Counter: mispredict_cnt increments on each branch_flush and wraps at 2^32.

Decomposition:
- Shared package: branch_update_t struct (pc, target, taken, is_branch, is_call, is_return, id) and the BLTU/BGEU fn3 constants (already in opcodes).
- One sub-module: branch_update_fifo, a generic DEPTH x branch_update_t FIFO with count output.
- The comparator is the existing branch_comparator, not a new sub-block.

Test Plan:
- BEQ rs1=rs2=5, pc=0x100, offset=0x20; next_pc=0x120 one cycle later -> branch_flush=0; update pushed with target=0x120, taken=1.
- BLT rs1=-1, rs2=1, pc=0x200, offset=0x10, fallthrough=0x204; next_pc=0x204 -> flush=1, flush_pc=0x210, mispredict_cnt=1. Same operands with BLTU -> not taken, no flush.
- JALR rs1=0x1003, offset=0 (C_EXT=0) -> target 0x1002, exc_valid=1 next cycle, no update. Repeat with C_EXT=1 -> no exception, flush_pc=0x1002.
- upd_ready held 0, UPD_DEPTH=4, four back-to-back resolved branches -> issue_ready falls to 0 once count+pending reaches 4. Releasing upd_ready -> entries drain in order, issue_ready returns to 1.
- Branch accepted, squash asserted in the resolve cycle with next_valid=1 -> no flush, no push; a branch accepted in that same cycle resolves normally afterwards.
- rst pulsed low mid-pending with FIFO holding 2 entries -> immediately pending=0, upd_valid=0, exc_valid=0, issue_ready=1.
